// File: rtl/vga_framebuffer_scanout.sv
// vga_framebuffer_scanout
// Holds a FB_W x FB_H x 3-bit framebuffer written by the sprite/background
// drawers and scans it out as a 2x-scaled VGA frame (640x480@60 with the
// default parameters). Also raises frame_tick for one clk at vblank start.
module vga_framebuffer_scanout #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_tick
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  // Screen timing in pixel ticks (horizontal) and lines (vertical).
  localparam logic [9:0] H_VIS    = 10'(2 * FB_W);
  localparam logic [9:0] HS_FIRST = 10'(2 * FB_W + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(2 * FB_W + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(2 * FB_W + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(2 * FB_H);
  localparam logic [9:0] VS_FIRST = 10'(2 * FB_H + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(2 * FB_H + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(2 * FB_H + V_FP + V_SYNC + V_BP - 1);

  logic       pix_en_q,  pix_en_d;
  logic [9:0] hcount_q,  hcount_d;
  logic [9:0] vcount_q,  vcount_d;
  logic       hs_q,      hs_d;
  logic       vs_q,      vs_d;
  logic       blank_n_q, blank_n_d;
  logic [2:0] rgb_q,     rgb_d;
  logic       tick_q,    tick_d;

  logic [2:0]    fb_mem [DEPTH];
  logic [2:0]    rd_colour;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          visible;

  // Write qualification and address mapping for both RAM ports.
  always_comb begin
    wr_en   = plot && (32'(x) < FB_W) && (32'(y) < FB_H);
    wr_addr = AW'(32'(y) * FB_W + 32'(x));
    // Each stored pixel covers a 2x2 screen block, so drop the counter LSBs.
    rd_addr = AW'(32'(vcount_q[9:1]) * FB_W + 32'(hcount_q[9:1]));
  end

  // Framebuffer: drawer write port plus scan-out read port.
  // NOTE: the array has no reset so it can map onto block RAM; reading and
  // writing with non-blocking assignments returns the old word on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= colour;
    end
    // Read on the clk just before each pixel tick, so it lines up with the
    // counters that the coming tick will display.
    if (!pix_en_q) begin
      rd_colour <= fb_mem[rd_addr];
    end
  end

  // Next-state logic: pixel tick, raster counters, registered VGA outputs.
  always_comb begin
    // NOTE: every output gets a hold value first, so no path leaves a latch.
    pix_en_d  = ~pix_en_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    visible   = (hcount_q < H_VIS) && (vcount_q < V_VIS);

    if (pix_en_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
      // Present the pixel the counters pointed at before this tick.
      blank_n_d = visible;
      hs_d      = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vs_d      = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      rgb_d     = visible ? rd_colour : 3'b000;
    end

    // Counters sit at (0, V_VIS) for two clks; pulse on the first of them.
    tick_d = !pix_en_q && (hcount_q == '0) && (vcount_q == V_VIS);
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_en_q  <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 3'b000;
      tick_q    <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      tick_q    <= tick_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};
  assign frame_tick  = tick_q;

endmodule
